// File: rtl/core_pkg.sv
// ============================================================================
// core_pkg : shared writeback-select and load-width encodings for the RV32I core
// Rev 1.0
// ============================================================================
`default_nettype none

package core_pkg;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2,
    WB_IMM = 2'd3
  } wb_sel_e;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

endpackage

`default_nettype wire

// File: rtl/mem_wb_stage_if.sv
// ============================================================================
// mem_wb_stage_if : MEM-stage result bundle feeding the MEM/WB boundary
// Rev 1.0
// ============================================================================
`default_nettype none

interface mem_wb_stage_if;
  logic        in_valid;
  logic        in_reg_write;
  logic [4:0]  in_rd;
  logic [1:0]  in_wb_sel;
  logic [31:0] in_alu_result;
  logic [31:0] in_pc4;
  logic [31:0] in_imm;
  logic [31:0] in_mem_rdata;
  logic [2:0]  in_funct3;

  modport master (
    output in_valid, in_reg_write, in_rd, in_wb_sel, in_alu_result,
           in_pc4, in_imm, in_mem_rdata, in_funct3
  );

  modport slave (
    input  in_valid, in_reg_write, in_rd, in_wb_sel, in_alu_result,
           in_pc4, in_imm, in_mem_rdata, in_funct3
  );
endinterface

`default_nettype wire

// File: rtl/mem_wb_stage_load_extract.sv
// ============================================================================
// load_extract : selects and sign/zero-extends load data from an aligned word
// Rev 1.0
// ============================================================================
`default_nettype none

module load_extract
  import core_pkg::*;
(
  input  wire logic [31:0] rdata,
  input  wire logic [2:0]  funct3,
  input  wire logic [1:0]  offset,
  output logic      [31:0] data
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    sel_byte = rdata[7:0];
    case (offset)
      2'd0:    sel_byte = rdata[7:0];
      2'd1:    sel_byte = rdata[15:8];
      2'd2:    sel_byte = rdata[23:16];
      default: sel_byte = rdata[31:24];
    endcase
  end

  // Halfword loads use only offset[1]; offset[0] is ignored
  assign sel_half = offset[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    data = rdata;
    case (funct3)
      F3_LB:   data = {{24{sel_byte[7]}}, sel_byte};
      F3_LBU:  data = {24'h0, sel_byte};
      F3_LH:   data = {{16{sel_half[15]}}, sel_half};
      F3_LHU:  data = {16'h0, sel_half};
      default: data = rdata;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_wb_stage.sv
// ============================================================================
// mem_wb_stage : MEM/WB pipeline register with writeback select and retire count
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_wb_stage
  import core_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              stall,
  input  wire logic              flush,
  mem_wb_stage_if.slave          mem,
  output logic                   RegWrite,
  output logic       [4:0]       Wt_addr,
  output logic       [31:0]      Wt_data,
  output logic                   wb_valid,
  output logic       [CNT_W-1:0] retired
);

  logic [31:0] load_data;
  logic [31:0] next_data;
  logic        capture;

  load_extract u_load_extract (
    .rdata  (mem.in_mem_rdata),
    .funct3 (mem.in_funct3),
    .offset (mem.in_alu_result[1:0]),
    .data   (load_data)
  );

  always_comb begin
    next_data = mem.in_alu_result;
    case (mem.in_wb_sel)
      WB_ALU:  next_data = mem.in_alu_result;
      WB_MEM:  next_data = load_data;
      WB_PC4:  next_data = mem.in_pc4;
      default: next_data = mem.in_imm;
    endcase
  end

  assign capture = !flush && !stall;

  // Flush clears only the valid/enable bits; address and data are left stale
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid <= 1'b0;
      RegWrite <= 1'b0;
      Wt_addr  <= 5'd0;
      Wt_data  <= 32'd0;
      retired  <= '0;
    end else if (flush) begin
      wb_valid <= 1'b0;
      RegWrite <= 1'b0;
    end else if (capture) begin
      wb_valid <= mem.in_valid;
      RegWrite <= mem.in_valid & mem.in_reg_write & (mem.in_rd != 5'd0);
      Wt_addr  <= mem.in_rd;
      Wt_data  <= next_data;
      if (mem.in_valid)
        retired <= retired + CNT_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
// ============================================================================
// tb_mem_wb_stage : directed vectors with a queued scoreboard for mem_wb_stage
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mem_wb_stage;
  import core_pkg::*;

  logic clk = 1'b0;
  logic rst, stall, flush;
  always #5 clk = ~clk;

  mem_wb_stage_if bus();

  logic        rw_a, v_a;
  logic [4:0]  addr_a;
  logic [31:0] data_a, ret_a;
  logic        rw_b, v_b;
  logic [4:0]  addr_b;
  logic [31:0] data_b;
  logic [3:0]  ret_b;

  mem_wb_stage #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .mem(bus),
    .RegWrite(rw_a), .Wt_addr(addr_a), .Wt_data(data_a), .wb_valid(v_a), .retired(ret_a)
  );

  mem_wb_stage #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .mem(bus),
    .RegWrite(rw_b), .Wt_addr(addr_b), .Wt_data(data_b), .wb_valid(v_b), .retired(ret_b)
  );

  typedef struct packed {
    logic        v;
    logic        rw;
    logic [4:0]  a;
    logic [31:0] d;
    logic [31:0] r;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int total = 0;
  int bad   = 0;

  logic        m_v, m_rw;
  logic [4:0]  m_a;
  logic [31:0] m_d, m_r;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h want %08h at %0t", n, act, exp, $time);
    end
  endtask

  // Monitor: one expected entry per registered result, sampled 1 unit after the edge
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      chk("wb_valid",   {31'h0, v_a},    {31'h0, mon_e.v});
      chk("RegWrite",   {31'h0, rw_a},   {31'h0, mon_e.rw});
      chk("Wt_addr",    {27'h0, addr_a}, {27'h0, mon_e.a});
      chk("Wt_data",    data_a,          mon_e.d);
      chk("retired",    ret_a,           mon_e.r);
      chk("retired_w4", {28'h0, ret_b},  {28'h0, mon_e.r[3:0]});
    end
  end

  task automatic cyc(input logic st, input logic fl, input logic v, input logic rw,
                     input logic [4:0] rd, input logic [1:0] sel, input logic [31:0] alu,
                     input logic [31:0] pc4, input logic [31:0] imm, input logic [31:0] rdata,
                     input logic [2:0] f3, input logic [31:0] exp_d);
    exp_t e;
    stall = st;
    flush = fl;
    bus.in_valid      = v;
    bus.in_reg_write  = rw;
    bus.in_rd         = rd;
    bus.in_wb_sel     = sel;
    bus.in_alu_result = alu;
    bus.in_pc4        = pc4;
    bus.in_imm        = imm;
    bus.in_mem_rdata  = rdata;
    bus.in_funct3     = f3;
    if (fl) begin
      m_v  = 1'b0;
      m_rw = 1'b0;
    end else if (!st) begin
      m_v  = v;
      m_rw = v & rw & (rd != 5'd0);
      m_a  = rd;
      m_d  = exp_d;
      if (v) m_r = m_r + 32'd1;
    end
    e.v = m_v; e.rw = m_rw; e.a = m_a; e.d = m_d; e.r = m_r;
    q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic ld(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] exp_d);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 5'd3, WB_MEM, {30'h400, off}, 32'h0, 32'h0,
        32'h80FF7F01, f3, exp_d);
  endtask

  task automatic alu_op(input logic [4:0] rd, input logic [31:0] val);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, rd, WB_ALU, val, 32'h0, 32'h0, 32'h0, F3_LW, val);
  endtask

  task automatic model_reset;
    m_v = 1'b0; m_rw = 1'b0; m_a = 5'd0; m_d = 32'd0; m_r = 32'd0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_wb_valid"}, {31'h0, v_a},    32'h0);
    chk({tag, "_RegWrite"}, {31'h0, rw_a},   32'h0);
    chk({tag, "_Wt_addr"},  {27'h0, addr_a}, 32'h0);
    chk({tag, "_Wt_data"},  data_a,          32'h0);
    chk({tag, "_retired"},  ret_a,           32'h0);
    chk({tag, "_ret_w4"},   {28'h0, ret_b},  32'h0);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    bus.in_valid = 1'b0; bus.in_reg_write = 1'b0; bus.in_rd = 5'd0;
    bus.in_wb_sel = 2'd0; bus.in_alu_result = 32'h0; bus.in_pc4 = 32'h0;
    bus.in_imm = 32'h0; bus.in_mem_rdata = 32'h0; bus.in_funct3 = 3'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    chk_zero("reset");

    // Load extraction from 0x80FF7F01
    ld(F3_LB,  2'd0, 32'h00000001);
    ld(F3_LB,  2'd1, 32'h0000007F);
    ld(F3_LB,  2'd2, 32'hFFFFFFFF);
    ld(F3_LB,  2'd3, 32'hFFFFFF80);
    ld(F3_LBU, 2'd3, 32'h00000080);
    ld(F3_LH,  2'd2, 32'hFFFF80FF);
    ld(F3_LH,  2'd1, 32'h00007F01);
    ld(F3_LHU, 2'd3, 32'h000080FF);
    ld(F3_LW,  2'd3, 32'h80FF7F01);
    ld(3'd7,   2'd1, 32'h80FF7F01);

    // Async reset mid-run while RegWrite is high
    rst = 1'b1;
    #1;
    chk_zero("async_rst");
    model_reset();
    @(posedge clk);
    #2;
    rst = 1'b0;

    // Writeback source sweep, rd=5
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 5'd5, WB_ALU, 32'h00001234, 32'h0, 32'h0, 32'h0, F3_LW, 32'h00001234);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 5'd5, WB_PC4, 32'h0, 32'h00000104, 32'h0, 32'h0, F3_LW, 32'h00000104);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 5'd5, WB_IMM, 32'h0, 32'h0, 32'hABCDE000, 32'h0, F3_LW, 32'hABCDE000);

    // x0 destination never asserts RegWrite but still retires
    alu_op(5'd0, 32'hDEADBEEF);
    // Bubble
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 5'd6, WB_ALU, 32'h66, 32'h0, 32'h0, 32'h0, F3_LW, 32'h66);

    // Capture rd=7, then stall three cycles with different inputs, then flush+stall
    alu_op(5'd7, 32'h00000055);
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 1'b0, 1'b1, 1'b1, 5'd9, WB_ALU, 32'h99, 32'h0, 32'h0, 32'h0, F3_LW, 32'h99);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 5'd9, WB_ALU, 32'h99, 32'h0, 32'h0, 32'h0, F3_LW, 32'h99);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 5'd10, WB_ALU, 32'hAA, 32'h0, 32'h0, 32'h0, F3_LW, 32'hAA);

    // Enough back-to-back captures to wrap the 4-bit counter
    for (int i = 0; i < 18; i++)
      alu_op(5'(i + 1), 32'h1000 + 32'(i));

    cyc(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, WB_ALU, 32'h0, 32'h0, 32'h0, 32'h0, F3_LW, 32'h0);
    repeat (3) @(posedge clk);
    #2;
    chk("queue_drained", 32'(q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
